cordic_fixedpoint_updatephase_seq: RTL

CORDIC_FIXEDPOINT_UPDATEPHASE_SEQ -- requirements
Module: cordic_fixedpoint_updatephase_seq

---
 rtl/cordic_fixedpoint_updatephase_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cordic_fixedpoint_updatephase_seq.sv
//-----------------------------------------------------------------------------
// Module  : cordic_fixedpoint_updatephase_seq
// Purpose : Sequential CORDIC phase-update engine. One micro-rotation per
//           cycle drives the residual angle z toward zero and records the
//           rotation direction chosen at each iteration.
// Ports   :
//   iClk            in   1   clock, rising edge
//   iReset          in   1   synchronous active-high reset
//   iStart          in   1   start request, sampled only in IDLE
//   iPhase_target   in  21   signed target angle, captured on start
//   iHold           in   1   freezes iteration while high
//   oAddr_theta     out  4   theta ROM address (iteration index in ITER)
//   iTheta_value    in  21   signed ROM data for oAddr_theta, same cycle
//   oDir            out 16   direction bits, bit i = iteration i (1 = sub)
//   oDir_valid      out  1   one pulse per executed iteration
//   oPhase_residual out 21   current residual angle z
//   oBusy           out  1   high outside IDLE
//   oDone           out  1   single-cycle completion pulse
// Config  : define CORDIC_UPDATEPHASE_SAT_EN to saturate z on overflow
//           instead of wrapping modulo 2^21.
// Rev     : 1.0  initial release
//-----------------------------------------------------------------------------
`default_nettype none

module cordic_fixedpoint_updatephase_seq #(
  parameter int NUM_ITER = 16
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [20:0] iPhase_target,
  input  logic        iHold,
  output logic [3:0]  oAddr_theta,
  input  logic [20:0] iTheta_value,
  output logic [15:0] oDir,
  output logic        oDir_valid,
  output logic [20:0] oPhase_residual,
  output logic        oBusy,
  output logic        oDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_ITER = 4'(NUM_ITER - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [20:0] z;
  logic        dir_bit;
  logic [20:0] z_next;

  // Rotate toward zero: subtract while z is non-negative.
  assign dir_bit = ~z[20];

`ifdef CORDIC_UPDATEPHASE_SAT_EN
  logic [21:0] sum_ext;

  // One guard bit: overflow shows as the top two bits disagreeing, and the
  // guard bit then carries the true sign of the result.
  always_comb begin
    sum_ext = dir_bit ? ({z[20], z} - {iTheta_value[20], iTheta_value})
                      : ({z[20], z} + {iTheta_value[20], iTheta_value});
    if (sum_ext[21] != sum_ext[20])
      z_next = sum_ext[21] ? 21'h100000 : 21'h0FFFFF;
    else
      z_next = sum_ext[20:0];
  end
`else
  assign z_next = dir_bit ? (z - iTheta_value) : (z + iTheta_value);
`endif

  assign oAddr_theta     = (state == ITER) ? cnt : 4'd0;
  assign oPhase_residual = z;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      z          <= 21'd0;
      oDir       <= 16'd0;
      oDir_valid <= 1'b0;
      oDone      <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      oDir_valid <= 1'b0;
      oDone      <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            z     <= iPhase_target;
            cnt   <= 4'd0;
            oDir  <= 16'd0;
            oBusy <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          if (!iHold) begin
            z          <= z_next;
            oDir[cnt]  <= dir_bit;
            oDir_valid <= 1'b1;
            // Counter parks on the last index rather than wrapping; the
            // next start reloads it.
            if (cnt == LAST_ITER) begin
              oDone <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
